// File: rtl/cosim_seq_pkg.sv
// Shared types and default constants for the cosim run sequencer and its
// reset-stagger helper.
package cosim_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ASSERT   = 3'd1,
    ST_RELEASE  = 3'd2,
    ST_WAIT_RDY = 3'd3,
    ST_RUN      = 3'd4,
    ST_DONE     = 3'd5,
    ST_ERROR    = 3'd6
  } cosim_seq_state_e;

  localparam int DEF_NUM_DOMAINS   = 4;
  localparam int DEF_RST_CYCLES    = 4;
  localparam int DEF_STAGGER       = 1;
  localparam int DEF_CNT_W         = 64;
  localparam int DEF_READY_TIMEOUT = 1024;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cosim_rst_stagger.sv
// Staggered reset release: clears dom_rst one domain at a time (domain 0
// first), STAGGER+1 cycles apart, and flags release_done after the last one.
module cosim_rst_stagger
  import cosim_seq_pkg::*;
#(
  parameter int NUM_DOMAINS = DEF_NUM_DOMAINS,
  parameter int STAGGER     = DEF_STAGGER
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   set_all,
  input  logic                   load,
  output logic [NUM_DOMAINS-1:0] dom_rst,
  output logic                   release_done
);

  localparam int IDX_W       = width_of(NUM_DOMAINS);
  localparam int GAP_W       = width_of(STAGGER + 1);
  localparam bit ALL_AT_ONCE = (STAGGER == 0) || (NUM_DOMAINS == 1);

  logic [NUM_DOMAINS-1:0] dom_rst_reg;
  logic [NUM_DOMAINS-1:0] clr_vec;
  logic [IDX_W-1:0]       idx_reg;
  logic [GAP_W-1:0]       gap_reg;
  logic                   active_reg;
  logic                   release_done_reg;
  logic                   step;

  assign step = active_reg && (gap_reg == '0);

  // Bit 0 (or every bit when unstaggered) drops on load; later bits on each step.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DOMAINS; gi++) begin : g_clr
      assign clr_vec[gi] = (load && ((gi == 0) || ALL_AT_ONCE)) ||
                           (step && (idx_reg == IDX_W'(gi)));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst || set_all) begin
      dom_rst_reg      <= '1;
      active_reg       <= 1'b0;
      release_done_reg <= 1'b0;
      idx_reg          <= '0;
      gap_reg          <= '0;
    end else begin
      dom_rst_reg <= dom_rst_reg & ~clr_vec;
      if (load) begin
        active_reg       <= !ALL_AT_ONCE;
        release_done_reg <= ALL_AT_ONCE;
        idx_reg          <= IDX_W'(1);
        gap_reg          <= GAP_W'(STAGGER);
      end else if (step) begin
        gap_reg <= GAP_W'(STAGGER);
        if (idx_reg == IDX_W'(NUM_DOMAINS - 1)) begin
          active_reg       <= 1'b0;
          release_done_reg <= 1'b1;
        end else begin
          idx_reg <= idx_reg + IDX_W'(1);
        end
      end else if (active_reg) begin
        gap_reg <= gap_reg - GAP_W'(1);
      end
    end
  end

  assign dom_rst      = dom_rst_reg;
  assign release_done = release_done_reg;

endmodule

// File: rtl/cosim_run_sequencer.sv
// Cosim run controller: reset handshake with staggered release, ready wait and
// a budgeted run. Define ESI_COSIM_READY_TIMEOUT_EN to enable the ready timeout.
module cosim_run_sequencer
  import cosim_seq_pkg::*;
#(
  parameter int NUM_DOMAINS   = DEF_NUM_DOMAINS,
  parameter int RST_CYCLES    = DEF_RST_CYCLES,
  parameter int STAGGER       = DEF_STAGGER,
  parameter int CNT_W         = DEF_CNT_W,
  parameter int READY_TIMEOUT = DEF_READY_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   stop_req,
  input  logic [CNT_W-1:0]       cycle_limit,
  input  logic [NUM_DOMAINS-1:0] dom_ready,
  output logic [NUM_DOMAINS-1:0] dom_rst,
  output logic                   running,
  output logic                   finish,
  output logic [CNT_W-1:0]       cycle_count,
  output logic                   timeout_err,
  output logic [2:0]             seq_state
);

  localparam int RST_W = width_of(RST_CYCLES);

  generate
    if (NUM_DOMAINS < 1 || NUM_DOMAINS > 16 || RST_CYCLES < 1 || STAGGER < 0 ||
        CNT_W < 1 || READY_TIMEOUT < 1) begin : g_param_check
      $error("cosim_run_sequencer: parameter out of range");
    end
  endgenerate

  cosim_seq_state_e state_reg, state_next;
  logic [CNT_W-1:0] limit_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [RST_W-1:0] rst_cnt_reg;
  logic             running_reg;
  logic             finish_reg;
  logic             start_acc;
  logic             rel_load;
  logic             rel_set_all;
  logic             release_done;
  logic             limit_hit;
  logic             timeout_hit;

  // A zero budget means unlimited, so it must never match the saturated count.
  assign limit_hit = (limit_reg != '0) && (cnt_reg == limit_reg - CNT_W'(1));

  always_comb begin
    state_next = state_reg;
    start_acc  = 1'b0;
    rel_load   = 1'b0;
    case (state_reg)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          state_next = ST_ASSERT;
          start_acc  = 1'b1;
        end
      end
      ST_ASSERT: begin
        if (rst_cnt_reg == '0) begin
          state_next = ST_RELEASE;
          rel_load   = 1'b1;
        end
      end
      ST_RELEASE:  if (release_done) state_next = ST_WAIT_RDY;
      ST_WAIT_RDY: begin
        if (&dom_ready)       state_next = ST_RUN;
        else if (timeout_hit) state_next = ST_ERROR;
      end
      ST_RUN:      if (stop_req || limit_hit) state_next = ST_DONE;
      default:     state_next = ST_IDLE;
    endcase
  end

  assign rel_set_all = (state_next == ST_IDLE) || (state_next == ST_ASSERT) ||
                       (state_next == ST_ERROR);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg   <= ST_IDLE;
      limit_reg   <= '0;
      cnt_reg     <= '0;
      rst_cnt_reg <= '0;
      running_reg <= 1'b0;
      finish_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      running_reg <= (state_next == ST_RUN);
      finish_reg  <= (state_next == ST_DONE) && (state_reg != ST_DONE);
      if (start_acc) begin
        limit_reg   <= cycle_limit;
        cnt_reg     <= '0;
        rst_cnt_reg <= RST_W'(RST_CYCLES - 1);
      end else begin
        if (state_reg == ST_RUN && cnt_reg != '1) cnt_reg <= cnt_reg + CNT_W'(1);
        if (state_reg == ST_ASSERT && rst_cnt_reg != '0) rst_cnt_reg <= rst_cnt_reg - RST_W'(1);
      end
    end
  end

`ifdef ESI_COSIM_READY_TIMEOUT_EN
  localparam int TO_W = width_of(READY_TIMEOUT);

  logic [TO_W-1:0] wait_cnt_reg;
  logic            timeout_err_reg;

  assign timeout_hit = (wait_cnt_reg == TO_W'(READY_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      wait_cnt_reg    <= '0;
      timeout_err_reg <= 1'b0;
    end else begin
      wait_cnt_reg <= (state_reg == ST_WAIT_RDY) ? wait_cnt_reg + TO_W'(1) : '0;
      if (start_acc)                   timeout_err_reg <= 1'b0;
      else if (state_next == ST_ERROR) timeout_err_reg <= 1'b1;
    end
  end

  assign timeout_err = timeout_err_reg;
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  cosim_rst_stagger #(
    .NUM_DOMAINS (NUM_DOMAINS),
    .STAGGER     (STAGGER)
  ) u_stagger (
    .clk          (clk),
    .rst          (rst),
    .set_all      (rel_set_all),
    .load         (rel_load),
    .dom_rst      (dom_rst),
    .release_done (release_done)
  );

  assign running     = running_reg;
  assign finish      = finish_reg;
  assign cycle_count = cnt_reg;
  assign seq_state   = state_reg;

endmodule
